// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled bit timing, 3-sample majority vote,
// start/parity/stop checking and one-cycle result pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state, w_next_state;
  logic                  r_sync1, r_sync2;
  logic [PRESCALE_W-1:0] r_prescale, r_edge_cnt;
  logic [BCW-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_samp_a, r_samp_b, r_bit_val;
  logic                  r_par_en, r_par_typ, r_bad;

  logic                  w_rx_s;
  logic [PRESCALE_W-1:0] w_half;
  logic                  w_at_s0, w_at_s1, w_at_vote, w_at_glitch, w_at_last;
  logic                  w_vote, w_exp_par, w_last_bit;
  logic                  w_deliver, w_par_fail, w_stp_fail;

  assign w_rx_s      = r_sync2;
  assign w_half      = r_prescale >> 1;
  assign w_at_s0     = (r_edge_cnt == w_half - PRESCALE_W'(2));
  assign w_at_s1     = (r_edge_cnt == w_half - PRESCALE_W'(1));
  assign w_at_vote   = (r_edge_cnt == w_half);
  assign w_at_glitch = (r_edge_cnt == w_half + PRESCALE_W'(1));
  assign w_at_last   = (r_edge_cnt == r_prescale - PRESCALE_W'(1));
  assign w_vote      = (r_samp_a & r_samp_b) | (r_samp_a & w_rx_s) | (r_samp_b & w_rx_s);
  assign w_exp_par   = (^r_shift) ^ r_par_typ;
  assign w_last_bit  = (r_bit_cnt == BCW'(DATA_WIDTH - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
    w_next_state = r_state;
    w_deliver    = 1'b0;
    w_par_fail   = 1'b0;
    w_stp_fail   = 1'b0;
    unique case (r_state)
      S_IDLE:   if (!w_rx_s) w_next_state = S_START;
      S_START: begin
        // r_bit_val holds the start-bit vote from the previous cycle.
        if (w_at_glitch && r_bit_val) w_next_state = S_IDLE;
        else if (w_at_last)           w_next_state = S_DATA;
      end
      S_DATA:   if (w_at_last && w_last_bit) w_next_state = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_at_last) begin
        w_next_state = S_STOP;
        w_par_fail   = (r_bit_val != w_exp_par);
      end
      S_STOP:   if (w_at_last) begin
        w_next_state = S_IDLE;
        w_stp_fail   = ~r_bit_val;
        w_deliver    = r_bit_val & ~r_bad;
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the shift register is a handful of flops, not a memory, so it is reset like the rest.
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_prescale <= '0;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_samp_a   <= 1'b1;
      r_samp_b   <= 1'b1;
      r_bit_val  <= 1'b1;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_bad      <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      r_sync1    <= RX_IN;
      r_sync2    <= r_sync1;
      Data_Valid <= w_deliver;
      Par_Err    <= w_par_fail;
      Stp_Err    <= w_stp_fail;
      if (w_deliver) P_DATA <= r_shift;

      if (r_state == S_IDLE) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= '0;
        if (!w_rx_s) begin
          r_prescale <= Prescale;
          r_par_en   <= PAR_EN;
          r_par_typ  <= PAR_TYP;
          r_bad      <= 1'b0;
        end
      end else begin
        r_edge_cnt <= w_at_last ? '0 : r_edge_cnt + PRESCALE_W'(1);
        if (w_at_s0) r_samp_a <= w_rx_s;
        if (w_at_s1) r_samp_b <= w_rx_s;
        if (w_at_vote) begin
          r_bit_val <= w_vote;
          if (r_state == S_DATA) r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
        end
        if (r_state == S_DATA && w_at_last)
          r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BCW'(1);
        if (w_par_fail) r_bad <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven on the negedge, outputs sampled on the negedge.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       Data_Valid, Par_Err, Stp_Err;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int n_dv = 0, n_pe = 0, n_se = 0, dv_cyc = 0;
  logic [7:0] dv_data[$];

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .Par_Err(Par_Err), .Stp_Err(Stp_Err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (Data_Valid) begin
      n_dv   = n_dv + 1;
      dv_cyc = cyc;
      dv_data.push_back(P_DATA);
    end
    if (Par_Err) n_pe = n_pe + 1;
    if (Stp_Err) n_se = n_se + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame; glitch_at flips the line for one clock at that offset, cut_at stops early.
  task automatic send_frame(input logic [7:0] data, input logic pe, input logic typ,
                            input logic par_bit, input logic stop_bit, input int p,
                            input int glitch_at, input int cut_at);
    logic bits [0:10];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    nb = 9;
    if (pe) begin
      bits[nb] = par_bit;
      nb = nb + 1;
    end
    bits[nb] = stop_bit;
    nb = nb + 1;
    PAR_EN   = pe;
    PAR_TYP  = typ;
    Prescale = 6'(p);
    fall_cyc = cyc;
    for (int o = 0; o < nb * p; o++) begin
      if (cut_at >= 0 && o == cut_at) break;
      RX_IN = bits[o / p] ^ (o == glitch_at);
      @(negedge CLK);
    end
  endtask

  task automatic expect_counts(input string name, input int dv0, input int pe0, input int se0,
                               input int ddv, input int dpe, input int dse);
    tests_run++;
    if (n_dv - dv0 !== ddv) begin
      tests_failed++;
      $display("FAIL %s data_valid pulses: got %0d expected %0d", name, n_dv - dv0, ddv);
    end
    tests_run++;
    if (n_pe - pe0 !== dpe) begin
      tests_failed++;
      $display("FAIL %s par_err pulses: got %0d expected %0d", name, n_pe - pe0, dpe);
    end
    tests_run++;
    if (n_se - se0 !== dse) begin
      tests_failed++;
      $display("FAIL %s stp_err pulses: got %0d expected %0d", name, n_se - se0, dse);
    end
  endtask

  task automatic expect_pdata(input string name, input logic [7:0] exp);
    tests_run++;
    if (P_DATA !== exp) begin
      tests_failed++;
      $display("FAIL %s p_data: got %02h expected %02h", name, P_DATA, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    tests_run++;
    if ({P_DATA, Data_Valid, Par_Err, Stp_Err} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset outputs: got %03h expected 000", {P_DATA, Data_Valid, Par_Err, Stp_Err});
    end
    RST = 1'b0;
    idle(10);
    expect_counts("reset_idle", 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_parity_good();
    int dv0 = n_dv, pe0 = n_pe, se0 = n_se;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8, -1, -1);
    idle(16);
    expect_counts("parity_good", dv0, pe0, se0, 1, 0, 0);
    expect_pdata("parity_good", 8'hA5);
    tests_run++;
    if (dv_cyc - fall_cyc < 90 || dv_cyc - fall_cyc > 92) begin
      tests_failed++;
      $display("FAIL latency: got %0d cycles expected 90..92", dv_cyc - fall_cyc);
    end
  endtask

  task automatic test_parity_error();
    int dv0 = n_dv, pe0 = n_pe, se0 = n_se;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8, -1, -1);
    idle(16);
    expect_counts("parity_err", dv0, pe0, se0, 0, 1, 0);
    expect_pdata("parity_err", 8'hA5);
  endtask

  task automatic test_stop_error();
    int dv0 = n_dv, pe0 = n_pe, se0 = n_se;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16, -1, -1);
    idle(24);
    expect_counts("stop_err", dv0, pe0, se0, 0, 0, 1);
    expect_pdata("stop_err", 8'hA5);
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 16, -1, -1);
    idle(24);
    expect_counts("after_stop_err", dv0, pe0, se0, 1, 0, 0);
    expect_pdata("after_stop_err", 8'h81);
  endtask

  task automatic test_start_glitch();
    int dv0 = n_dv, pe0 = n_pe, se0 = n_se;
    Prescale = 6'd16;
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    idle(40);
    expect_counts("start_glitch", dv0, pe0, se0, 0, 0, 0);
    // 0x5A has four ones, so odd parity needs a 1.
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 16, -1, -1);
    idle(24);
    expect_counts("after_glitch", dv0, pe0, se0, 1, 0, 0);
    expect_pdata("after_glitch", 8'h5A);
  endtask

  task automatic test_data_glitch();
    int dv0 = n_dv, pe0 = n_pe, se0 = n_se;
    // Bit 3 of 0xC3 is 0; flip the middle of its three samples (offset 4*8+4).
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8, 36, -1);
    idle(16);
    expect_counts("data_glitch", dv0, pe0, se0, 1, 0, 0);
    expect_pdata("data_glitch", 8'hC3);
  endtask

  task automatic test_back_to_back();
    int dv0 = n_dv, pe0 = n_pe, se0 = n_se;
    int q0 = dv_data.size();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 32, -1, -1);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 32, -1, -1);
    idle(40);
    expect_counts("back_to_back", dv0, pe0, se0, 2, 0, 0);
    tests_run++;
    if (dv_data.size() !== q0 + 2 || dv_data[q0] !== 8'h55 || dv_data[q0+1] !== 8'hAA) begin
      tests_failed++;
      $display("FAIL back_to_back bytes: got %0d new (%02h %02h) expected 2 (55 aa)",
               dv_data.size() - q0, dv_data[q0], dv_data[q0+1]);
    end
    expect_pdata("back_to_back", 8'hAA);
  endtask

  task automatic test_reset_mid_frame();
    int dv0 = n_dv, pe0 = n_pe, se0 = n_se;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 32, -1, 160);
    RST = 1'b1;
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    tests_run++;
    if ({P_DATA, Data_Valid, Par_Err, Stp_Err} !== 11'd0) begin
      tests_failed++;
      $display("FAIL mid_frame_reset outputs: got %03h expected 000",
               {P_DATA, Data_Valid, Par_Err, Stp_Err});
    end
    RST = 1'b0;
    idle(400);
    expect_counts("mid_frame_reset", dv0, pe0, se0, 0, 0, 0);
    expect_pdata("mid_frame_reset", 8'h00);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_parity_good();
    test_parity_error();
    test_stop_error();
    test_start_glitch();
    test_data_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the line driven by the UART transmitter's TX_OUT.
- Oversamples RX_IN at Prescale clocks per bit and majority-votes three mid-bit samples per bit.
- Checks start, optional parity and stop bits, and delivers the received byte as P_DATA with a one-cycle Data_Valid pulse.
- Frame format matches the transmitter: start(0), 8 data bits LSB first, optional parity, stop(1).

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_W, 6, width of the Prescale input and of the internal edge counter.

Ports:
- CLK  in  1  system clock; oversampling clock.
- RST  in  1  asynchronous reset, active-high.
- RX_IN  in  1  serial line; idle high; asynchronous to CLK.
- PAR_EN  in  1  1 = a parity bit follows the data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- Prescale  in  PRESCALE_W  clocks per bit; legal values are even and 6..62.
- P_DATA  out  DATA_WIDTH  last good byte; held between frames.
- Data_Valid  out  1  one-cycle pulse when P_DATA is updated.
- Par_Err  out  1  one-cycle pulse on a parity mismatch.
- Stp_Err  out  1  one-cycle pulse when the stop bit is sampled as 0.

Behaviour:
- Reset values: P_DATA=0, Data_Valid=0, Par_Err=0, Stp_Err=0. Reset puts the FSM in IDLE and clears the counters, shift register and synchronizer (both stages to 1). Reset mid-frame abandons the frame and produces no pulses.
- Synchronizer: RX_IN passes through 2 flops; rx_s is the synchronized value. All line decisions use rx_s.
- Counters: edge_cnt runs 0..P-1 and wraps, where P is the Prescale latched on leaving IDLE. bit_cnt runs 0..DATA_WIDTH-1. Prescale changes mid-frame are ignored.
- Sampling: with h = P/2, the samples are taken at edge_cnt = h-2, h-1 and h. The bit value is the majority of the three, computed at edge_cnt = h.
- FSM states: IDLE, START, DATA, PARITY, STOP. Every non-IDLE state advances when edge_cnt == P-1.
  - IDLE: when rx_s == 0, latch P, set edge_cnt=0 and go to START.
  - START: if the voted bit is 1 (glitch), return to IDLE at edge_cnt = h+1 with no pulses. Otherwise go to DATA at the end of the bit.
  - DATA: shift the voted bits in LSB first. After bit DATA_WIDTH-1 completes, go to PARITY if PAR_EN=1, else STOP.
  - PARITY: compute expected = XOR(data) XOR PAR_TYP. On a mismatch, pulse Par_Err at edge_cnt = P-1 and mark the frame bad. Then go to STOP.
  - STOP: at edge_cnt = P-1:
    - voted stop bit 0: pulse Stp_Err.
    - voted stop bit 1 and frame not bad: load P_DATA and pulse Data_Valid.
    - in either case, go to IDLE.
- Pulse outputs are registered: one cycle wide, asserted in the cycle after the deciding edge.
- Par_Err and Stp_Err can both occur in one frame. Data_Valid never accompanies an error in the same frame.
- Back-to-back frames: IDLE is re-entered after the stop bit, and a start bit low on the next cycle is accepted. This gives zero idle bits between frames.
- PAR_EN and PAR_TYP are sampled on leaving IDLE and held for the frame.
- Line held low continuously: the first frame gives Stp_Err. The FSM then restarts from IDLE each frame and produces Stp_Err per frame; there is no lockup.
- Latency: Data_Valid rises (2 + frame_bits*P + 1) cycles after the RX_IN falling edge, with a ±1-cycle synchronizer uncertainty.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity bit 0 and stop 1 -> one Data_Valid pulse, P_DATA=0xA5, no error pulses.
- Same frame with PAR_TYP=1, parity bit sent as 0 -> Par_Err pulse once, no Data_Valid, P_DATA keeps its previous value.
- Prescale=16, PAR_EN=0, byte 0x3C with stop bit forced to 0 -> Stp_Err pulse, no Data_Valid. A following good 0x81 frame -> Data_Valid with P_DATA=0x81.
- RX_IN low for 2 clocks in IDLE at Prescale=16 -> FSM returns to IDLE, no pulses; a following valid frame is received correctly.
- A single-clock glitch on a mid-bit sample of data bit 3 at Prescale=8 -> the majority vote rejects it and the byte is received correctly.
- Two frames 0x55 then 0xAA sent back-to-back with no idle bits, Prescale=32 -> two Data_Valid pulses with the correct bytes. Asserting RST mid-way through a third frame -> all outputs return to 0 and no pulse occurs.
